// File: rtl/fir_output_checker_pkg.sv
// fir_types: shared state encoding and default sample/table types for the FIR output checker.
package fir_types;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int FIR_DATA_W = 16;
  localparam int FIR_DEPTH = 4;
  typedef logic signed [FIR_DATA_W-1:0] sample_t;
  typedef sample_t table_t [FIR_DEPTH];
endpackage

// File: rtl/fir_output_checker_table.sv
// fir_expected_table: reset-free table of expected samples, one sync write port, one comb read port.
module fir_expected_table import fir_types::*; #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]         raddr_i,
  output logic signed [DATA_W-1:0] rdata_o
);
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i && 32'(waddr_i) < DEPTH) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fir_output_checker.sv
// fir_output_checker: compares valid FIR samples in order against a loadable table within a tolerance.
module fir_output_checker import fir_types::*; #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = 16,
  parameter int TOL = 0,
  parameter int LOOP = 0
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  logic signed [DATA_W-1:0] cfg_data,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     mismatch,
  output logic [IDX_W-1:0]         exp_idx,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [IDX_W-1:0]         first_err_idx,
  output logic                     first_err_vld,
  output logic [CNT_W-1:0]         pass_cnt
);
  localparam logic [DATA_W:0] TOL_V = (DATA_W+1)'(TOL);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH-1);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, ferr_idx_q, ferr_idx_d;
  logic [CNT_W-1:0] err_q, err_d, pcnt_q, pcnt_d;
  logic ferr_vld_q, ferr_vld_d, mism_q, mism_d;
  logic signed [DATA_W-1:0] exp_s;
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0] adiff;
  logic accept, miss, last;
  fir_expected_table #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
    .clk_i   (system1000),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (idx_q),
    .rdata_o (exp_s)
  );
  // One extra bit keeps the difference of two extreme samples from wrapping.
  assign diff = {in_data[DATA_W-1], in_data} - {exp_s[DATA_W-1], exp_s};
  assign adiff = diff[DATA_W] ? -diff : diff;
  assign accept = state_q == RUN && in_valid && !start;
  assign miss = accept && adiff > TOL_V;
  assign last = idx_q == LAST;
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = start ? RUN : (accept && last && LOOP == 0) ? DONE : state_q;
  always_comb begin
    idx_d = start ? '0 : accept ? (last ? '0 : idx_q + 1'b1) : idx_q;
    err_d = start ? '0 : (miss && ~&err_q) ? err_q + 1'b1 : err_q;
    pcnt_d = start ? '0 : (accept && last && LOOP != 0 && ~&pcnt_q) ? pcnt_q + 1'b1 : pcnt_q;
    ferr_vld_d = !start && (ferr_vld_q || miss);
    ferr_idx_d = start ? '0 : (miss && !ferr_vld_q) ? idx_q : ferr_idx_q;
    mism_d = miss;
  end
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) begin
      idx_q <= '0;
      err_q <= '0;
      pcnt_q <= '0;
      ferr_vld_q <= 1'b0;
      ferr_idx_q <= '0;
      mism_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
      pcnt_q <= pcnt_d;
      ferr_vld_q <= ferr_vld_d;
      ferr_idx_q <= ferr_idx_d;
      mism_q <= mism_d;
    end
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
    pass = state_q == DONE && err_q == '0;
    mismatch = mism_q;
    exp_idx = idx_q;
    err_cnt = err_q;
    first_err_idx = ferr_idx_q;
    first_err_vld = ferr_vld_q;
    pass_cnt = pcnt_q;
  end
`ifndef SYNTHESIS
  always_ff @(posedge system1000)
    if (miss) $display("fir_output_checker: t=%0t idx=%0d expected=%0d actual=%0d", $time, idx_q, exp_s, in_data);
`endif
endmodule

// File: doc/fir_output_checker.md
Name: fir_output_checker

Overview:
- Parametrised successor to the FIR single-bit output verifier.
- Holds a DEPTH-entry table of expected signed samples, loaded at run time through a write port.
- Compares each valid DUT sample against the table in order, within an absolute tolerance.
- Reports mismatch count, first-failing index, pass/done status and, in loop mode, completed-pass count. Sits beside the FIR DUT in testbench tops and self-checking FPGA builds.

Parameters:
DATA_W, 16, width of signed DUT and expected samples
DEPTH, 4, number of expected samples (>=2)
IDX_W, $clog2(DEPTH), index width
CNT_W, 16, width of error and pass counters
TOL, 0, maximum allowed |actual-expected| (unsigned, < 2**(DATA_W-1))
LOOP, 0, 1 = wrap index to 0 after DEPTH-1 and keep checking; 0 = stop in DONE

Ports:
system1000  in  1  clock
system1000_rst  in  1  asynchronous reset, active high
cfg_we  in  1  table write strobe
cfg_addr  in  IDX_W  table write address
cfg_data  in  DATA_W  signed expected value
start  in  1  single-cycle pulse, begins a run
in_valid  in  1  DUT sample valid
in_data  in  DATA_W  signed DUT sample
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  done && err_cnt==0
mismatch  out  1  registered one-cycle pulse: previous accepted sample failed
exp_idx  out  IDX_W  index of next sample to be checked
err_cnt  out  CNT_W  mismatches since start, saturating at all-ones
first_err_idx  out  IDX_W  index of first mismatch in this run
first_err_vld  out  1  first_err_idx is meaningful
pass_cnt  out  CNT_W  completed table traversals (LOOP=1), saturating

Behaviour:
- Reset (async, active high): state IDLE; all outputs 0; table contents undefined and not cleared.
- States:
  - IDLE: start -> RUN.
  - RUN: accepts samples.
  - DONE: start -> RUN. DONE is reached only with LOOP=0.
- On start (IDLE or DONE): exp_idx, err_cnt, first_err_vld, first_err_idx, pass_cnt cleared. The first sample is accepted no earlier than the cycle after start.
- start while in RUN restarts: counters clear and the sample in that cycle is ignored.
- Accept: in_valid in RUN. Compare is combinational against table[exp_idx].
  - diff is computed at DATA_W+1 bits signed, then absolute value; match if |diff| <= TOL. No overflow possible at DATA_W+1.
- All effects of an accepted sample are registered and visible the next cycle (latency 1):
  - mismatch pulse and err_cnt += 1 on mismatch.
  - On the first mismatch only: first_err_idx = exp_idx, first_err_vld = 1.
- exp_idx increments per accepted sample. At DEPTH-1:
  - LOOP=1: wrap to 0 and pass_cnt += 1.
  - LOOP=0: go to DONE. The same registered update applies the final sample's err_cnt.
- Non-power-of-two DEPTH: index wraps at DEPTH-1, never reaches DEPTH.
- in_valid outside RUN: ignored, no counter change.
- Table writes:
  - Allowed in any state; take effect the next cycle.
  - A write to table[exp_idx] in the same cycle as an accept does not affect that compare (old value used).
  - cfg_addr >= DEPTH is ignored.
- Counters saturate; no wrap.
- Reset asserted mid-run aborts immediately to IDLE with outputs cleared.
- Simulation-only (translate_off): on a mismatch, print time, index, expected and actual values. No $stop.

Decomposition:
- Package fir_types:
  - checker state enum {IDLE, RUN, DONE}.
  - Typedef for signed sample of DATA_W.
  - Array typedef for the table.
- Sub-module fir_expected_table:
  - DEPTH x DATA_W register file.
  - One synchronous write port (with address range check).
  - One combinational read port.
  - Reset-free.
- FSM, comparator and counters live in fir_output_checker.

Test Plan:
1. DEPTH=4, TOL=0, LOOP=0: load {4,12,1,20}, start, feed 4,12,1,20 on consecutive cycles -> done=1, pass=1, err_cnt=0, busy=0 one cycle after the 4th sample.
2. Same load, feed 4,13,1,19 -> mismatch pulses after samples 2 and 4, err_cnt=2, first_err_idx=1, first_err_vld=1, pass=0.
3. TOL=1, feed 5,11,1,21 -> pass=1. Feed -32768 against expected 32767 -> mismatch (wide diff, no wrap).
4. LOOP=1, 3 clean traversals with gaps in in_valid -> pass_cnt=3, exp_idx=0, done=0, busy=1, err_cnt=0.
5. Mid-run: after 2 samples, assert system1000_rst one cycle -> all outputs 0, state IDLE. Then start again and 4 good samples -> pass=1. Separately, start during RUN clears err_cnt=1 back to 0.
6. Write table[1]=99 while exp_idx=1 is accepted with in_data=12 -> match (old value used). Next traversal (LOOP=1) with 12 -> mismatch. Write to cfg_addr=5 with DEPTH=5 -> ignored (DEPTH=5, IDX_W=3 build).
